// File: rtl/ie_request_arbiter_pkg.sv
// ie_pkg: shared IE type encodings and arbiter FSM state encoding
package ie_pkg;
    localparam logic [2:0] IE_TYPE_PROT = 3'b001;
    localparam logic [2:0] IE_TYPE_PF   = 3'b010;
    localparam logic [2:0] IE_TYPE_INT  = 3'b100;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, SERVICE} ie_state_t;
endpackage

// File: rtl/ie_request_arbiter_if.sv
// ie_request_arbiter_if: request/context inputs and IE handler outputs of the arbiter
interface ie_request_arbiter_if #(
    parameter int EIP_W    = 32,
    parameter int EFLAGS_W = 18,
    parameter int CS_W     = 16
);
    logic                prot_req;
    logic                pf_req;
    logic                int_req;
    logic                is_resteer;
    logic [EIP_W-1:0]    EIP_WB;
    logic [EFLAGS_W-1:0] EFLAGS_WB;
    logic [CS_W-1:0]     CS_WB;
    logic                servicing_IE;
    logic                IE_out;
    logic [2:0]          IE_type_out;
    logic [EIP_W-1:0]    EIP_out;
    logic [EFLAGS_W-1:0] EFLAGS_out;
    logic [CS_W-1:0]     CS_out;
    logic                int_ack;
    logic                ie_busy;
    logic                double_fault;
    modport slave (
        input  prot_req, pf_req, int_req, is_resteer, EIP_WB, EFLAGS_WB, CS_WB, servicing_IE,
        output IE_out, IE_type_out, EIP_out, EFLAGS_out, CS_out, int_ack, ie_busy, double_fault
    );
    modport master (
        output prot_req, pf_req, int_req, is_resteer, EIP_WB, EFLAGS_WB, CS_WB, servicing_IE,
        input  IE_out, IE_type_out, EIP_out, EFLAGS_out, CS_out, int_ack, ie_busy, double_fault
    );
endinterface

// File: rtl/ie_request_arbiter_prio_enc.sv
// ie_prio_enc: fixed-priority one-hot grant, bit 0 (prot) highest, bit 2 (int) lowest
module ie_prio_enc (
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic       any
);
    // lowest set bit wins
    always_comb begin
        grant = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
        any   = |req;
    end
endmodule

// File: rtl/ie_request_arbiter.sv
// ie_request_arbiter: prioritises prot/pf/int requests and sequences the IE handler; IE_STAT_EN adds per-type issue counters
module ie_request_arbiter
    import ie_pkg::*;
#(
    parameter int EIP_W    = 32,
    parameter int EFLAGS_W = 18,
    parameter int CS_W     = 16,
    parameter int IF_BIT   = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    ie_request_arbiter_if.slave  bus
`ifdef IE_STAT_EN
    ,
    output logic [15:0]          prot_cnt,
    output logic [15:0]          pf_cnt,
    output logic [15:0]          int_cnt
);
`else
);
`endif
    ie_state_t           state;
    logic                prot_pend, pf_pend, int_el, any, issue_go, fault_req;
    logic [2:0]          grant, win;
    logic [EIP_W-1:0]    eip_q;
    logic [EFLAGS_W-1:0] eflags_q;
    logic [CS_W-1:0]     cs_q;
    assign int_el     = bus.int_req & bus.EFLAGS_WB[IF_BIT];
    assign fault_req  = bus.prot_req | bus.pf_req;
    assign issue_go   = (state == IDLE) & any & ~bus.is_resteer;
    assign bus.ie_busy    = state != IDLE;
    assign bus.EIP_out    = eip_q;
    assign bus.EFLAGS_out = eflags_q;
    assign bus.CS_out     = cs_q;
    ie_prio_enc u_enc (
        .req   ({int_el, pf_pend, prot_pend}),
        .grant (grant),
        .any   (any)
    );
    // handler sequencing FSM with registered one-cycle issue outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            win             <= 3'b000;
            bus.IE_out      <= 1'b0;
            bus.IE_type_out <= 3'b000;
            bus.int_ack     <= 1'b0;
        end else begin
            bus.IE_out      <= 1'b0;
            bus.IE_type_out <= 3'b000;
            bus.int_ack     <= 1'b0;
            case (state)
                IDLE: if (issue_go) begin
                    state           <= ISSUE;
                    win             <= grant;
                    bus.IE_out      <= 1'b1;
                    bus.IE_type_out <= grant;
                    bus.int_ack     <= grant == IE_TYPE_INT;
                end
                ISSUE:    state <= WAIT_ACK;
                WAIT_ACK: state <= bus.servicing_IE ? SERVICE : WAIT_ACK;
                SERVICE:  state <= bus.servicing_IE ? SERVICE : IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
    // pending faults, captured context and sticky double-fault flag
    always_ff @(posedge clk) begin
        if (reset) begin
            prot_pend        <= 1'b0;
            pf_pend          <= 1'b0;
            eip_q            <= '0;
            eflags_q         <= '0;
            cs_q             <= '0;
            bus.double_fault <= 1'b0;
        end else begin
            prot_pend <= bus.prot_req | (prot_pend & ~((state == ISSUE) & (win == IE_TYPE_PROT)));
            pf_pend   <= bus.pf_req | (pf_pend & ~((state == ISSUE) & (win == IE_TYPE_PF)));
            if (fault_req || (issue_go && grant == IE_TYPE_INT)) begin
                eip_q    <= bus.EIP_WB;
                eflags_q <= bus.EFLAGS_WB;
                cs_q     <= bus.CS_WB;
            end
            if (fault_req && (state == WAIT_ACK || state == SERVICE))
                bus.double_fault <= 1'b1;
        end
    end
`ifdef IE_STAT_EN
    // saturating per-type issue counters
    always_ff @(posedge clk) begin
        if (reset) begin
            prot_cnt <= '0;
            pf_cnt   <= '0;
            int_cnt  <= '0;
        end else if (state == ISSUE) begin
            prot_cnt <= prot_cnt + 16'((win == IE_TYPE_PROT) && prot_cnt != 16'hFFFF);
            pf_cnt   <= pf_cnt + 16'((win == IE_TYPE_PF) && pf_cnt != 16'hFFFF);
            int_cnt  <= int_cnt + 16'((win == IE_TYPE_INT) && int_cnt != 16'hFFFF);
        end
    end
`endif
endmodule
